systolic_tile_scheduler: RTL and testbench

Tile-level sequencer for the 32x32 output-stationary systolic array. On START it latches the M/K/N problem sizes and walks the output matrix tile by tile. Per tile it issues K operand-SRAM reads, waits out the array skew, then writes the valid accumulator rows to the output SRAM. It replaces the ad-hoc control inside the array top and ends each job with a one-cycle IS_FINISHED_out pulse.

---
 rtl/systolic_tile_scheduler_pkg.sv | 35 +++
 rtl/systolic_tile_scheduler_tile_counter.sv | 84 ++++++++
 rtl/systolic_tile_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_systolic_tile_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_tile_scheduler_pkg.sv
// Shared types and helpers for the systolic tile scheduler and the array top.
// Size typedefs are reused by the array datapath.
package systolic_tile_scheduler_pkg;

  localparam int unsigned ArrayRows    = 32;
  localparam int unsigned ArrayCols    = 32;
  localparam int unsigned MaxMSizeLog2 = 9;
  localparam int unsigned MaxKSizeLog2 = 9;
  localparam int unsigned MaxNSizeLog2 = 9;
  localparam int unsigned SramAwidth   = 11;
  localparam int unsigned DrainCycles  = ArrayRows + ArrayCols - 1;

  typedef logic [MaxMSizeLog2-1:0] m_size_t;
  typedef logic [MaxKSizeLog2-1:0] k_size_t;
  typedef logic [MaxNSizeLog2-1:0] n_size_t;

  typedef enum logic [2:0] {
    StIdle,
    StFeed,
    StDrain,
    StWrite,
    StDone
  } sched_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Row-major linear address; callers truncate to the SRAM address width.
  function automatic int unsigned lin_addr(input int unsigned outer, input int unsigned stride,
                                           input int unsigned inner);
    return outer * stride + inner;
  endfunction

endpackage

// File: rtl/systolic_tile_scheduler_tile_counter.sv
// Nested m/n/k/r position counter for the tile scheduler. Exposes both current and
// next values so the top can register its outputs from the next position.
module systolic_tile_scheduler_tile_counter #(
  parameter int unsigned MW = 9,
  parameter int unsigned NW = 9,
  parameter int unsigned KW = 9,
  parameter int unsigned RW = 5
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          stall,
  input  logic          clear,
  input  logic          k_inc,
  input  logic          r_inc,
  input  logic          tile_adv,
  input  logic [KW-1:0] k_size,
  input  logic [RW:0]   row_limit,
  input  logic [MW-1:0] m_tiles,
  input  logic [NW-1:0] n_tiles,
  output logic [MW-1:0] m_tile_q,
  output logic [MW-1:0] m_tile_d,
  output logic [NW-1:0] n_tile_d,
  output logic [KW-1:0] k_d,
  output logic [RW-1:0] r_d,
  output logic          k_last,
  output logic          r_last,
  output logic          n_last,
  output logic          m_last
);

  localparam int unsigned RLW = RW + 1;

  logic [NW-1:0] n_tile_q;
  logic [KW-1:0] k_q;
  logic [RW-1:0] r_q;

  assign k_last = (k_q == k_size - KW'(1));
  assign r_last = ({1'b0, r_q} == row_limit - RLW'(1));
  assign n_last = (n_tile_q == n_tiles - NW'(1));
  assign m_last = (m_tile_q == m_tiles - MW'(1));

  // n is the inner tile loop; k and r restart on every tile.
  always_comb begin
    m_tile_d = m_tile_q;
    n_tile_d = n_tile_q;
    k_d      = k_q;
    r_d      = r_q;
    if (clear) begin
      m_tile_d = '0;
      n_tile_d = '0;
      k_d      = '0;
      r_d      = '0;
    end else if (!stall) begin
      if (tile_adv) begin
        k_d = '0;
        r_d = '0;
        if (n_last) begin
          n_tile_d = '0;
          m_tile_d = m_tile_q + MW'(1);
        end else begin
          n_tile_d = n_tile_q + NW'(1);
        end
      end else begin
        if (k_inc) k_d = k_q + KW'(1);
        if (r_inc) r_d = r_q + RW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_tile_q <= '0;
      n_tile_q <= '0;
      k_q      <= '0;
      r_q      <= '0;
    end else begin
      m_tile_q <= m_tile_d;
      n_tile_q <= n_tile_d;
      k_q      <= k_d;
      r_q      <= r_d;
    end
  end

endmodule

// File: rtl/systolic_tile_scheduler.sv
// Tile-level sequencer for the output-stationary systolic array: feeds K operand reads per
// tile, waits out the array skew, then writes the valid accumulator rows.
module systolic_tile_scheduler
  import systolic_tile_scheduler_pkg::*;
#(
  parameter int unsigned PE_ARRAY_NUM_ROWS = ArrayRows,
  parameter int unsigned PE_ARRAY_NUM_COLS = ArrayCols,
  parameter int unsigned MAX_M_SIZE_LOG2   = MaxMSizeLog2,
  parameter int unsigned MAX_K_SIZE_LOG2   = MaxKSizeLog2,
  parameter int unsigned MAX_N_SIZE_LOG2   = MaxNSizeLog2,
  parameter int unsigned OPND1_SRAM_AWIDTH = SramAwidth,
  parameter int unsigned OPND2_SRAM_AWIDTH = SramAwidth,
  parameter int unsigned OUT_SRAM_AWIDTH   = SramAwidth,
  parameter int unsigned DRAIN_CYCLES      = DrainCycles
) (
  input  logic                                 CLK,
  input  logic                                 RSTn,
  input  logic                                 START,
  input  logic                                 STALL,
  input  logic [MAX_M_SIZE_LOG2-1:0]           M_SIZE_in,
  input  logic [MAX_K_SIZE_LOG2-1:0]           K_SIZE_in,
  input  logic [MAX_N_SIZE_LOG2-1:0]           N_SIZE_in,
  output logic                                 OPND_RD_EN_out,
  output logic [OPND1_SRAM_AWIDTH-1:0]         OPND1_ADDR_out,
  output logic [OPND2_SRAM_AWIDTH-1:0]         OPND2_ADDR_out,
  output logic                                 ACC_CLEAR_out,
  output logic [$clog2(PE_ARRAY_NUM_ROWS)-1:0] ROW_SEL_out,
  output logic                                 OUT_WR_EN_out,
  output logic [OUT_SRAM_AWIDTH-1:0]           OUT_ADDR_out,
  output logic                                 BUSY_out,
  output logic                                 IS_FINISHED_out
);

  localparam int unsigned MW      = MAX_M_SIZE_LOG2;
  localparam int unsigned KW      = MAX_K_SIZE_LOG2;
  localparam int unsigned NW      = MAX_N_SIZE_LOG2;
  localparam int unsigned RowW    = $clog2(PE_ARRAY_NUM_ROWS);
  localparam int unsigned RowLimW = RowW + 1;
  localparam int unsigned DrainW  = $clog2(DRAIN_CYCLES + 1);

  sched_state_e state_q, state_d;

  logic [MW-1:0]     m_size_q, m_size_d, m_tiles_q, m_tiles_d;
  logic [KW-1:0]     k_size_q, k_size_d;
  logic [NW-1:0]     n_tiles_q, n_tiles_d;
  logic              empty_q, empty_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              accept, k_inc, r_inc, tile_adv;

  logic [MW-1:0]      m_tile_q, m_tile_d;
  logic [NW-1:0]      n_tile_d;
  logic [KW-1:0]      k_d;
  logic [RowW-1:0]    r_d;
  logic               k_last, r_last, n_last, m_last;
  logic [RowLimW-1:0] row_limit;

  logic                         rd_en_d, acc_clear_d, wr_en_d, busy_d, finished_d;
  logic [OPND1_SRAM_AWIDTH-1:0] opnd1_addr_d;
  logic [OPND2_SRAM_AWIDTH-1:0] opnd2_addr_d;
  logic [OUT_SRAM_AWIDTH-1:0]   out_addr_d;
  logic [RowW-1:0]              row_sel_d;

  systolic_tile_scheduler_tile_counter #(
    .MW(MW),
    .NW(NW),
    .KW(KW),
    .RW(RowW)
  ) u_tile_counter (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .stall    (STALL),
    .clear    (accept),
    .k_inc    (k_inc),
    .r_inc    (r_inc),
    .tile_adv (tile_adv),
    .k_size   (k_size_q),
    .row_limit(row_limit),
    .m_tiles  (m_tiles_q),
    .n_tiles  (n_tiles_q),
    .m_tile_q (m_tile_q),
    .m_tile_d (m_tile_d),
    .n_tile_d (n_tile_d),
    .k_d      (k_d),
    .r_d      (r_d),
    .k_last   (k_last),
    .r_last   (r_last),
    .n_last   (n_last),
    .m_last   (m_last)
  );

  // Sizes and tile counts are captured only when a job is accepted.
  always_comb begin
    m_size_d  = m_size_q;
    k_size_d  = k_size_q;
    m_tiles_d = m_tiles_q;
    n_tiles_d = n_tiles_q;
    empty_d   = empty_q;
    if (accept) begin
      m_size_d  = M_SIZE_in;
      k_size_d  = K_SIZE_in;
      m_tiles_d = MW'(ceil_div(32'(M_SIZE_in), PE_ARRAY_NUM_ROWS));
      n_tiles_d = NW'(ceil_div(32'(N_SIZE_in), PE_ARRAY_NUM_COLS));
      empty_d   = (M_SIZE_in == '0) || (K_SIZE_in == '0) || (N_SIZE_in == '0);
    end
  end

  // Valid rows of the current M tile; the last tile may be partial.
  always_comb begin
    int unsigned rows_left;
    rows_left = 32'(m_size_q) - 32'(m_tile_q) * PE_ARRAY_NUM_ROWS;
    row_limit = (rows_left >= PE_ARRAY_NUM_ROWS) ? RowLimW'(PE_ARRAY_NUM_ROWS)
                                                 : RowLimW'(rows_left);
  end

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    accept   = 1'b0;
    k_inc    = 1'b0;
    r_inc    = 1'b0;
    tile_adv = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START && !STALL) begin
          accept  = 1'b1;
          state_d = StFeed;
        end
      end
      StFeed: begin
        if (!STALL) begin
          if (empty_q) begin
            state_d = StDone;
          end else if (k_last) begin
            state_d = StDrain;
            drain_d = '0;
          end else begin
            k_inc = 1'b1;
          end
        end
      end
      StDrain: begin
        if (!STALL) begin
          if (drain_q == DrainW'(DRAIN_CYCLES - 1)) state_d = StWrite;
          else drain_d = drain_q + DrainW'(1);
        end
      end
      StWrite: begin
        if (!STALL) begin
          if (r_last) begin
            if (m_last && n_last) begin
              state_d = StDone;
            end else begin
              state_d  = StFeed;
              tile_adv = 1'b1;
            end
          end else begin
            r_inc = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next position and registered alongside it.
  always_comb begin
    rd_en_d      = (state_d == StFeed) && !empty_d && !STALL;
    acc_clear_d  = rd_en_d && (k_d == '0);
    wr_en_d      = (state_d == StWrite) && !STALL;
    opnd1_addr_d = OPND1_SRAM_AWIDTH'(lin_addr(32'(m_tile_d), 32'(k_size_d), 32'(k_d)));
    opnd2_addr_d = OPND2_SRAM_AWIDTH'(lin_addr(32'(n_tile_d), 32'(k_size_d), 32'(k_d)));
    out_addr_d   = OUT_SRAM_AWIDTH'(lin_addr(lin_addr(32'(m_tile_d), PE_ARRAY_NUM_ROWS, 32'(r_d)),
                                             32'(n_tiles_d), 32'(n_tile_d)));
    row_sel_d    = r_d;
    busy_d       = (state_d != StIdle);
    finished_d   = (state_d == StDone);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q         <= StIdle;
      drain_q         <= '0;
      m_size_q        <= '0;
      k_size_q        <= '0;
      m_tiles_q       <= '0;
      n_tiles_q       <= '0;
      empty_q         <= 1'b0;
      OPND_RD_EN_out  <= 1'b0;
      ACC_CLEAR_out   <= 1'b0;
      OUT_WR_EN_out   <= 1'b0;
      OPND1_ADDR_out  <= '0;
      OPND2_ADDR_out  <= '0;
      OUT_ADDR_out    <= '0;
      ROW_SEL_out     <= '0;
      BUSY_out        <= 1'b0;
      IS_FINISHED_out <= 1'b0;
    end else begin
      state_q         <= state_d;
      drain_q         <= drain_d;
      m_size_q        <= m_size_d;
      k_size_q        <= k_size_d;
      m_tiles_q       <= m_tiles_d;
      n_tiles_q       <= n_tiles_d;
      empty_q         <= empty_d;
      OPND_RD_EN_out  <= rd_en_d;
      ACC_CLEAR_out   <= acc_clear_d;
      OUT_WR_EN_out   <= wr_en_d;
      OPND1_ADDR_out  <= opnd1_addr_d;
      OPND2_ADDR_out  <= opnd2_addr_d;
      OUT_ADDR_out    <= out_addr_d;
      ROW_SEL_out     <= row_sel_d;
      BUSY_out        <= busy_d;
      IS_FINISHED_out <= finished_d;
    end
  end

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Scoreboard bench for systolic_tile_scheduler: a loop-level job model fills expected
// read/write/finish queues, and a negedge monitor pops and compares them.
module tb_systolic_tile_scheduler;

  logic        CLK;
  logic        RSTn;
  logic        START;
  logic        STALL;
  logic [8:0]  M_SIZE_in, K_SIZE_in, N_SIZE_in;
  logic        OPND_RD_EN_out;
  logic [10:0] OPND1_ADDR_out, OPND2_ADDR_out, OUT_ADDR_out;
  logic        ACC_CLEAR_out;
  logic [4:0]  ROW_SEL_out;
  logic        OUT_WR_EN_out;
  logic        BUSY_out;
  logic        IS_FINISHED_out;

  systolic_tile_scheduler u_dut (
    .CLK            (CLK),
    .RSTn           (RSTn),
    .START          (START),
    .STALL          (STALL),
    .M_SIZE_in      (M_SIZE_in),
    .K_SIZE_in      (K_SIZE_in),
    .N_SIZE_in      (N_SIZE_in),
    .OPND_RD_EN_out (OPND_RD_EN_out),
    .OPND1_ADDR_out (OPND1_ADDR_out),
    .OPND2_ADDR_out (OPND2_ADDR_out),
    .ACC_CLEAR_out  (ACC_CLEAR_out),
    .ROW_SEL_out    (ROW_SEL_out),
    .OUT_WR_EN_out  (OUT_WR_EN_out),
    .OUT_ADDR_out   (OUT_ADDR_out),
    .BUSY_out       (BUSY_out),
    .IS_FINISHED_out(IS_FINISHED_out)
  );

  typedef struct {
    int a1;
    int a2;
    int clr;
  } rd_t;

  typedef struct {
    int addr;
    int row;
  } wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];
  int  fin_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endfunction

  // Reference: walk tiles with n inner, m outer; each tile costs K + 63 + valid rows.
  task automatic model_job(input int m, input int k, input int n, input int extra);
    int  mt, nt, total, v;
    rd_t r;
    wr_t w;
    if (m == 0 || k == 0 || n == 0) begin
      total = 1;
    end else begin
      mt    = (m + 31) / 32;
      nt    = (n + 31) / 32;
      total = 0;
      for (int mi = 0; mi < mt; mi++) begin
        for (int ni = 0; ni < nt; ni++) begin
          for (int kk = 0; kk < k; kk++) begin
            r.a1  = (mi * k + kk) % 2048;
            r.a2  = (ni * k + kk) % 2048;
            r.clr = (kk == 0) ? 1 : 0;
            rd_q.push_back(r);
          end
          v = (m - mi * 32 < 32) ? m - mi * 32 : 32;
          for (int rr = 0; rr < v; rr++) begin
            w.addr = ((mi * 32 + rr) * nt + ni) % 2048;
            w.row  = rr;
            wr_q.push_back(w);
          end
          total += k + 63 + v;
        end
      end
    end
    fin_q.push_back(cyc + 1 + total + extra);
  endtask

  always @(negedge CLK) begin
    rd_t er;
    wr_t ew;
    if (RSTn) begin
      if (OPND_RD_EN_out) begin
        if (rd_q.size() == 0) flag("rd_unexpected");
        else begin
          er = rd_q.pop_front();
          chk("opnd1_addr", int'(OPND1_ADDR_out), er.a1);
          chk("opnd2_addr", int'(OPND2_ADDR_out), er.a2);
          chk("acc_clear", int'(ACC_CLEAR_out), er.clr);
        end
      end else if (ACC_CLEAR_out) begin
        flag("acc_clear_without_read");
      end
      if (OUT_WR_EN_out) begin
        if (wr_q.size() == 0) flag("wr_unexpected");
        else begin
          ew = wr_q.pop_front();
          chk("out_addr", int'(OUT_ADDR_out), ew.addr);
          chk("row_sel", int'(ROW_SEL_out), ew.row);
        end
      end
      if (IS_FINISHED_out) begin
        if (fin_q.size() == 0) flag("finish_unexpected");
        else begin
          chk("finish_cycle", cyc, fin_q.pop_front());
          chk("reads_left_at_finish", rd_q.size(), 0);
          chk("writes_left_at_finish", wr_q.size(), 0);
          chk("busy_in_done", int'(BUSY_out), 1);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, int'(OPND_RD_EN_out), 0);
    chk({tag, "_wr_en"}, int'(OUT_WR_EN_out), 0);
    chk({tag, "_acc_clear"}, int'(ACC_CLEAR_out), 0);
    chk({tag, "_opnd1"}, int'(OPND1_ADDR_out), 0);
    chk({tag, "_opnd2"}, int'(OPND2_ADDR_out), 0);
    chk({tag, "_out_addr"}, int'(OUT_ADDR_out), 0);
    chk({tag, "_row_sel"}, int'(ROW_SEL_out), 0);
    chk({tag, "_busy"}, int'(BUSY_out), 0);
    chk({tag, "_finished"}, int'(IS_FINISHED_out), 0);
  endtask

  task automatic start_job(input int m, input int k, input int n, input int extra);
    @(negedge CLK);
    model_job(m, k, n, extra);
    M_SIZE_in = 9'(m);
    K_SIZE_in = 9'(k);
    N_SIZE_in = 9'(n);
    START     = 1'b1;
    @(negedge CLK);
    START     = 1'b0;
    M_SIZE_in = 9'($urandom);
    K_SIZE_in = 9'($urandom);
    N_SIZE_in = 9'($urandom);
    chk("busy_after_start", int'(BUSY_out), 1);
  endtask

  task automatic wait_done();
    int limit;
    limit = (fin_q.size() > 0) ? fin_q[$] + 20 : cyc + 20;
    while (fin_q.size() > 0 && cyc <= limit) @(negedge CLK);
    if (fin_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL finish_timeout: no finish by cycle %0d, required by %0d", cyc, fin_q[0]);
      rd_q.delete();
      wr_q.delete();
      fin_q.delete();
    end
    @(negedge CLK);
    chk("idle_after_done", int'(BUSY_out), 0);
  endtask

  initial begin
    int m, k, n;
    RSTn      = 1'b0;
    START     = 1'b0;
    STALL     = 1'b0;
    M_SIZE_in = '0;
    K_SIZE_in = '0;
    N_SIZE_in = '0;
    #3;
    check_all_zero("reset");
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;

    start_job(32, 32, 32, 0);
    wait_done();

    start_job(32, 0, 32, 0);
    wait_done();

    // START with STALL in IDLE must not be taken.
    @(negedge CLK);
    M_SIZE_in = 9'd32;
    K_SIZE_in = 9'd32;
    N_SIZE_in = 9'd32;
    START     = 1'b1;
    STALL     = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    STALL = 1'b0;
    repeat (2) @(negedge CLK);
    chk("start_blocked_by_stall", int'(BUSY_out), 0);

    // Stall five cycles with k=9 on the bus; k=10 follows afterwards.
    start_job(32, 32, 32, 5);
    repeat (9) @(negedge CLK);
    STALL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_rd_en", int'(OPND_RD_EN_out), 0);
      chk("stall_acc_clear", int'(ACC_CLEAR_out), 0);
      chk("stall_opnd1_frozen", int'(OPND1_ADDR_out), 9);
      chk("stall_opnd2_frozen", int'(OPND2_ADDR_out), 9);
    end
    STALL = 1'b0;
    wait_done();

    // Reset in the middle of DRAIN aborts the job without a finish pulse.
    start_job(32, 32, 32, 0);
    repeat (40) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check_all_zero("midjob_reset");
    rd_q.delete();
    wr_q.delete();
    fin_q.delete();
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;

    // Partial M tile; a second START while busy is ignored.
    start_job(40, 32, 32, 0);
    repeat (3) @(negedge CLK);
    M_SIZE_in = 9'd3;
    K_SIZE_in = 9'd3;
    N_SIZE_in = 9'd3;
    START     = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done();

    start_job(256, 256, 256, 0);
    wait_done();

    for (int j = 0; j < 8; j++) begin
      m = int'($urandom_range(1, 80));
      k = int'($urandom_range(1, 20));
      n = int'($urandom_range(1, 70));
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       m = 0;
          1:       k = 0;
          default: n = 0;
        endcase
      end
      start_job(m, k, n, 0);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
